a23_io_loader: RTL
==================

Name: a23_io_loader

Overview:
- Hardware host-side front end for a23_gc_main.
- Receives program, garbler and evaluator words over a 32-bit valid/ready input stream and assembles them into the flat p_init/g_init/e_init buses.
- Holds the core in reset until loading completes, then releases it.
- When the core raises terminate, snapshots the flat o bus and drains it word by word over a 32-bit valid/ready output stream.

Parameters:
- CODE_MEM_SIZE, 512, program words (p_init depth)
- G_MEM_SIZE, 64, garbler input words
- E_MEM_SIZE, 64, evaluator input words
- OUT_MEM_SIZE, 64, output words

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid&&in_ready
- in_data  in  32  input word
- p_init  out  CODE_MEM_SIZE*32  to core; word i at [32i+31:32i]
- g_init  out  G_MEM_SIZE*32  to core, same packing
- e_init  out  E_MEM_SIZE*32  to core, same packing
- core_rst  out  1  reset to a23_gc_main
- terminate  in  1  from core
- o  in  OUT_MEM_SIZE*32  from core, word i at [32i+31:32i]
- out_valid  out  1  output word valid
- out_ready  in  1  downstream ready
- out_data  out  32  output word
- out_last  out  1  marks final output word
- done  out  1  drain complete

Behaviour:
- Reset: one clock (clk), reset synchronous and active-high (rst). All outputs are registered.
- Reset values: state LOAD, word counter 0; p_init/g_init/e_init/snapshot all 0; core_rst=1; in_ready=0; out_valid=0; out_data=0; out_last=0; done=0.
- States: LOAD -> RUN -> DRAIN -> DONE.
- Any cycle with rst=1 returns to the reset values, from any state including mid-load and mid-drain.
- LOAD:
  - in_ready=1 from the first cycle after rst deasserts.
  - Total input words N = CODE+G+E, in order: code words 0..CODE-1, then g words, then e words.
  - On each handshake, counter k selects the destination:
    - k<CODE: p_init word k
    - k<CODE+G: g_init word k-CODE
    - otherwise: e_init word k-CODE-G
  - Then k increments. Counter width is clog2(N+1).
  - On the handshake with k=N-1: in_ready=0 and core_rst=0 starting the next cycle; state becomes RUN.
  - terminate is ignored in LOAD.
  - in_data is ignored when in_ready=0.
- RUN:
  - core_rst=0. Init buses hold their values.
  - On the first cycle terminate=1: capture o into the snapshot register, set core_rst=1 the next cycle (freezes the core), set out_valid=1 with out_data=snapshot word 0, and enter DRAIN.
  - Core cycle count equals the number of RUN cycles, for debug.
- DRAIN:
  - out_data is snapshot word j; out_last=(j==OUT-1).
  - On out_valid&&out_ready: j increments and out_data updates next cycle.
  - out_valid stays high, and out_data is stable, while out_ready=0 (AXI-style hold).
  - On the handshake with out_last: out_valid=0, out_last=0, done=1 next cycle; state becomes DONE.
- DONE: done=1, core_rst=1, all streams idle. Only rst exits DONE.
- Later changes on o or terminate do not affect the snapshot.
- Throughput: one word per cycle on both streams with continuous valid/ready. Latency from last input handshake to core_rst=0 is 1 cycle.
- OUT_MEM_SIZE=1: first word asserts out_last immediately.

Decomposition:
- Include file a23_io_defines.vh holds the state encodings (LOAD=0, RUN=1, DRAIN=2, DONE=3) and the clog2 function.
- Sub-module a23_out_drain:
  - inputs: snapshot-load strobe, o bus, out_ready
  - outputs: out_valid/out_data/out_last/done
  - internal: snapshot register plus index counter
- Top level holds the load FSM and the init buses.

Test Plan:
1. Parameters CODE=4,G=2,E=2,OUT=3. Stream 0x100..0x107 with in_valid held high -> p_init words=0x100..0x103, g_init=0x104,0x105, e_init=0x106,0x107. core_rst falls exactly 1 cycle after the 8th handshake; in_ready=0 thereafter.
2. Same load with in_valid toggling every other cycle, and garbage data while in_valid=0 -> identical bus contents. Garbage on in_data after load is not written.
3. Pulse terminate after 10 RUN cycles with o words {0xA,0xB,0xC}; out_ready=1 -> out_data 0xA,0xB,0xC on consecutive cycles, out_last only on 0xC, done=1 the next cycle, core_rst=1.
4. Drain with out_ready low for 3 cycles on word 1 -> out_valid and out_data=0xB held stable; changing o after terminate does not alter the output.
5. Assert rst after the 5th input handshake -> all init buses 0, core_rst=1, in_ready=0 during rst. A full reload then succeeds.
6. terminate=1 throughout LOAD -> no snapshot, no out_valid until after RUN is entered.

Source files
------------

// File: rtl/a23_io_loader_pkg.sv
// Shared types and helpers for the a23 host-side loader and output drain.
// State encodings and the compile-time clog2 used for counter sizing.
package a23_io_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int WORD_W = 32;

    // Bits needed to index 'value' distinct items.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/a23_out_drain.sv
// Snapshots the core's flat output bus on a strobe, then streams it out
// one word per valid/ready handshake, flagging the final word with out_last.
module a23_out_drain
    import a23_io_loader_pkg::*;
#(
    parameter int OUT_MEM_SIZE = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           snap_load,
    input  logic [OUT_MEM_SIZE*WORD_W-1:0] o,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [WORD_W-1:0]              out_data,
    output logic                           out_last,
    output logic                           done
);

    localparam int JW = (OUT_MEM_SIZE > 1) ? clog2(OUT_MEM_SIZE) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(OUT_MEM_SIZE - 1);

    logic [OUT_MEM_SIZE*WORD_W-1:0] snap_q;
    logic [JW-1:0]                  j_q;
    logic [JW-1:0]                  j_next;

    assign j_next = j_q + JW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q    <= '0;
            j_q       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else if (snap_load) begin
            snap_q    <= o;
            j_q       <= '0;
            out_valid <= 1'b1;
            out_data  <= o[WORD_W-1:0];
            out_last  <= (J_LAST == '0);
        end else if (out_valid && out_ready) begin
            if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                done      <= 1'b1;
            end else begin
                j_q      <= j_next;
                out_data <= snap_q[32'(j_next)*WORD_W +: WORD_W];
                out_last <= (j_next == J_LAST);
            end
        end
    end

endmodule

// File: rtl/a23_io_loader.sv
// Host-side front end for a23_gc_main: streams program/garbler/evaluator words
// into the init buses, holds the core in reset until loaded, then drains o.
module a23_io_loader
    import a23_io_loader_pkg::*;
#(
    parameter int CODE_MEM_SIZE = 512,
    parameter int G_MEM_SIZE    = 64,
    parameter int E_MEM_SIZE    = 64,
    parameter int OUT_MEM_SIZE  = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WORD_W-1:0]               in_data,
    output logic [CODE_MEM_SIZE*WORD_W-1:0] p_init,
    output logic [G_MEM_SIZE*WORD_W-1:0]    g_init,
    output logic [E_MEM_SIZE*WORD_W-1:0]    e_init,
    output logic                            core_rst,
    input  logic                            terminate,
    input  logic [OUT_MEM_SIZE*WORD_W-1:0]  o,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WORD_W-1:0]               out_data,
    output logic                            out_last,
    output logic                            done
);

    localparam int N  = CODE_MEM_SIZE + G_MEM_SIZE + E_MEM_SIZE;
    localparam int CW = clog2(N + 1);
    localparam logic [CW-1:0] K_LAST   = CW'(N - 1);
    localparam logic [CW-1:0] K_G_BASE = CW'(CODE_MEM_SIZE);
    localparam logic [CW-1:0] K_E_BASE = CW'(CODE_MEM_SIZE + G_MEM_SIZE);

    state_t        state_q, state_d;
    logic [CW-1:0] k_q;
    logic          in_ready_d, core_rst_d;
    logic          in_fire, snap_load;

    assign in_fire  = in_valid && in_ready;

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        in_ready_d = 1'b0;
        core_rst_d = 1'b1;
        snap_load  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready_d = 1'b1;
                if (in_fire && k_q == K_LAST) begin
                    state_d    = ST_RUN;
                    in_ready_d = 1'b0;
                    core_rst_d = 1'b0;
                end
            end
            ST_RUN: begin
                core_rst_d = terminate;
                if (terminate) begin
                    snap_load = 1'b1;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid && out_ready && out_last) state_d = ST_DONE;
            end
            default: state_d = ST_DONE;
        endcase
    end

    // NOTE: the init buses are plain flops, not RAM, so they can and must clear on reset;
    // the core reads them directly and must never see a stale program after a reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            k_q      <= '0;
            in_ready <= 1'b0;
            core_rst <= 1'b1;
            p_init   <= '0;
            g_init   <= '0;
            e_init   <= '0;
        end else begin
            state_q  <= state_d;
            in_ready <= in_ready_d;
            core_rst <= core_rst_d;
            if (in_fire) begin
                k_q <= k_q + CW'(1);
                if (k_q < K_G_BASE)
                    p_init[32'(k_q)*WORD_W +: WORD_W] <= in_data;
                else if (k_q < K_E_BASE)
                    g_init[32'(k_q - K_G_BASE)*WORD_W +: WORD_W] <= in_data;
                else
                    e_init[32'(k_q - K_E_BASE)*WORD_W +: WORD_W] <= in_data;
            end
        end
    end

    a23_out_drain #(
        .OUT_MEM_SIZE (OUT_MEM_SIZE)
    ) u_drain (
        .clk       (clk),
        .rst       (rst),
        .snap_load (snap_load),
        .o         (o),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );

endmodule
